imem_fetch: RTL

Parametrised, loadable instruction memory for the LEGv8 core, replacing the fixed combinational ROM.
- Clears its storage after reset, then accepts program words through a load port.
- Serves instruction fetches through a valid/ready request/response handshake with one-cycle registered read latency.
- Sits between the fetch stage (PC word address) and the decode stage.

---
 rtl/imem_pkg.sv | 14 +
 rtl/imem_ram.sv | 39 +++
 rtl/imem_fetch.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared types and helpers for the loadable LEGv8 instruction memory.
package imem_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } imem_state_t;

    function automatic int depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/imem_ram.sv
// DEPTH x N single-port storage: synchronous write, registered read that holds
// its value until the next read strobe.
module imem_ram
    import imem_pkg::*;
#(
    parameter int N      = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [N-1:0]      wdata,
    output logic [N-1:0]      rdata
);

    localparam int DEPTH = depth(ADDR_W);

    logic [N-1:0] mem_q [DEPTH];
    logic [N-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/imem_fetch.sv
// Loadable instruction memory: CLEAR -> LOAD -> RUN sequencing with a
// valid/ready fetch port. Optional range check via IMEM_RANGE_CHECK_EN.
//
//   state | meaning
//   CLEAR | zero one word per cycle, DEPTH cycles, then LOAD
//   LOAD  | load port open, prog_len tracks highest address + 1
//   RUN   | fetches served; ld_mode drains the response then returns to LOAD
module imem_fetch
    import imem_pkg::*;
#(
    parameter int N      = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_mode,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [N-1:0]      ld_data,
    output logic              ld_ready,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [N-1:0]      rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W:0]   prog_len
);

    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(depth(ADDR_W) - 1);

    imem_state_t       state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic [ADDR_W:0]   prog_len_q;
    logic [ADDR_W:0]   prog_len_d;
    logic [ADDR_W:0]   ld_len;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic              fetch_acc;
    logic              fetch_err;

    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [N-1:0]      ram_wdata;
    logic [N-1:0]      ram_rdata;

    assign ld_ready  = (state_q == LOAD);
    assign req_ready = (state_q == RUN) && (!rsp_valid_q || rsp_ready) && !ld_mode;
    assign fetch_acc = req_valid && req_ready;

`ifdef IMEM_RANGE_CHECK_EN
    logic req_oor;
    assign req_oor   = ({1'b0, req_addr} >= prog_len_q);
    assign fetch_err = req_oor;
`else
    assign fetch_err = 1'b0;
`endif

    // Widened by one bit so a write to the last word reports the full depth.
    assign ld_len     = {1'b0, ld_addr} + {{ADDR_W{1'b0}}, 1'b1};
    assign prog_len_d = (ld_we && (ld_len > prog_len_q)) ? ld_len : prog_len_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            prog_len_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    clr_cnt_q  <= clr_cnt_q + 1'b1;
                    prog_len_q <= '0;
                    if (clr_cnt_q == CLR_LAST) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    prog_len_q <= prog_len_d;
                    if (!ld_mode) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (fetch_acc) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= fetch_err;
                    end else if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                    end
                    // Only leave once nothing is left for the consumer.
                    if (ld_mode && !rsp_valid_q) begin
                        state_q <= LOAD;
                    end
                end
                default: begin
                    state_q <= CLEAR;
                end
            endcase
        end
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = req_addr;
        ram_wdata = ld_data;
        case (state_q)
            CLEAR: begin
                ram_we    = 1'b1;
                ram_addr  = clr_cnt_q;
                ram_wdata = '0;
            end
            LOAD: begin
                ram_we   = ld_we;
                ram_addr = ld_addr;
            end
            RUN: begin
                ram_re = fetch_acc && !fetch_err;
            end
            default: begin
                ram_we = 1'b0;
            end
        endcase
    end

    imem_ram #(
        .N      (N),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // An out-of-range response leaves the read register untouched; mask it.
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_err_q ? '0 : ram_rdata;
    assign prog_len  = prog_len_q;

endmodule
